// File: rtl/pwm_multi_ch.sv
// pwm_multi_ch: N-channel PWM timer with a shared prescaler and counter.
// Period, prescaler and duty are double-buffered into shadows at the update event.
// Each channel has a complementary high/low output pair with programmable dead-time.
// Ports:
//   clk, rst           - clock, asynchronous active-high reset
//   wr_en, addr,       - register write strobe, address and data
//   wr_data
//   rd_en, rd_data     - read strobe and registered read data
//   pwm_h, pwm_l       - per-channel high/low outputs
//   upd_evt            - one-clk pulse after each update event
module pwm_multi_ch #(
   parameter int WIDTH = 16,
   parameter int NCH   = 4,
   parameter int DT_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic             rd_en,
   input  logic [3:0]       addr,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic [NCH-1:0]   pwm_h,
   output logic [NCH-1:0]   pwm_l,
   output logic             upd_evt
);

   localparam logic [3:0] A_CTRL   = 4'd0;
   localparam logic [3:0] A_PERIOD = 4'd1;
   localparam logic [3:0] A_PRESC  = 4'd2;
   localparam logic [3:0] A_DT     = 4'd3;

   logic [1:0]       ctrl_q, ctrl_d;
   logic [WIDTH-1:0] period_q, period_d;
   logic [WIDTH-1:0] presc_q, presc_d;
   logic [DT_W-1:0]  dt_q, dt_d;
   logic [WIDTH-1:0] duty_q [NCH];
   logic [WIDTH-1:0] duty_d [NCH];

   logic [WIDTH-1:0] period_sh_q, period_sh_d;
   logic [WIDTH-1:0] presc_sh_q, presc_sh_d;
   logic [WIDTH-1:0] duty_sh_q [NCH];
   logic [WIDTH-1:0] duty_sh_d [NCH];

   logic [WIDTH-1:0] psc_q, psc_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             dir_q, dir_d;
   logic             upd_q, upd_d;
   logic [NCH-1:0]   ref_q, ref_d;
   logic [DT_W-1:0]  dtc_q [NCH];
   logic [DT_W-1:0]  dtc_d [NCH];
   logic [NCH-1:0]   pwm_h_q, pwm_h_d;
   logic [NCH-1:0]   pwm_l_q, pwm_l_d;
   logic [WIDTH-1:0] rd_data_q, rd_data_d;
   logic [WIDTH-1:0] rd_mux;

   logic en, center, tick;

   assign en      = ctrl_q[0];
   assign center  = ctrl_q[1];
   assign tick    = en && (psc_q == presc_sh_q);
   assign rd_data = rd_data_q;
   assign pwm_h   = pwm_h_q;
   assign pwm_l   = pwm_l_q;
   assign upd_evt = upd_q;

   // Register file writes and registered reads (reads see pre-write values).
   always_comb begin
      ctrl_d   = ctrl_q;
      period_d = period_q;
      presc_d  = presc_q;
      dt_d     = dt_q;
      duty_d   = duty_q;
      rd_mux   = '0;
      if (wr_en) begin
         case (addr)
            A_CTRL:   ctrl_d   = wr_data[1:0];
            A_PERIOD: period_d = wr_data;
            A_PRESC:  presc_d  = wr_data;
            A_DT:     dt_d     = wr_data[DT_W-1:0];
            default:  ;
         endcase
         for (int i = 0; i < NCH; i++)
            if (addr == 4'(4 + i)) duty_d[i] = wr_data;
      end
      case (addr)
         A_CTRL:   rd_mux[1:0]      = ctrl_q;
         A_PERIOD: rd_mux           = period_q;
         A_PRESC:  rd_mux           = presc_q;
         A_DT:     rd_mux[DT_W-1:0] = dt_q;
         default:  ;
      endcase
      for (int i = 0; i < NCH; i++)
         if (addr == 4'(4 + i)) rd_mux = duty_q[i];
      rd_data_d = rd_en ? rd_mux : rd_data_q;
   end

   // Prescaler and counter. In center mode dir_q=1 means counting down;
   // reaching 0 on the way down is turned around by the cnt==0 branch.
   always_comb begin
      psc_d = '0;
      cnt_d = cnt_q;
      dir_d = dir_q;
      upd_d = 1'b0;
      if (!en) begin
         cnt_d = '0;
         dir_d = 1'b0;
      end else begin
         psc_d = tick ? '0 : psc_q + WIDTH'(1);
         if (!center) dir_d = 1'b0;
         if (tick) begin
            if (!center) begin
               if (cnt_q >= period_sh_q) begin
                  cnt_d = '0;
                  upd_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + WIDTH'(1);
               end
            end else if (period_sh_q == '0) begin
               cnt_d = '0;
               dir_d = 1'b0;
               upd_d = 1'b1;
            end else if (cnt_q == '0) begin
               cnt_d = WIDTH'(1);
               dir_d = 1'b0;
               upd_d = 1'b1;
            end else if (!dir_q) begin
               if (cnt_q >= period_sh_q) begin
                  cnt_d = cnt_q - WIDTH'(1);
                  dir_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + WIDTH'(1);
               end
            end else begin
               cnt_d = cnt_q - WIDTH'(1);
            end
         end
      end
   end

   // Shadows track the active registers while idle, else load on update.
   always_comb begin
      period_sh_d = period_sh_q;
      presc_sh_d  = presc_sh_q;
      duty_sh_d   = duty_sh_q;
      if (!en || upd_d) begin
         period_sh_d = period_q;
         presc_sh_d  = presc_q;
         duty_sh_d   = duty_q;
      end
   end

   // Compare and dead-time. dtc counts clks since ref last changed; an
   // output may assert only once that count reaches the dead-time.
   always_comb begin
      ref_d   = '0;
      pwm_h_d = '0;
      pwm_l_d = '0;
      dtc_d   = dtc_q;
      for (int i = 0; i < NCH; i++) begin
         ref_d[i] = en && (cnt_q < duty_sh_q[i]);
         if (!en || (ref_d[i] != ref_q[i]))
            dtc_d[i] = '0;
         else if (dtc_q[i] != '1)
            dtc_d[i] = dtc_q[i] + DT_W'(1);
         pwm_h_d[i] = en && ref_q[i] && (dtc_q[i] >= dt_q);
         pwm_l_d[i] = en && !ref_q[i] && (dtc_q[i] >= dt_q);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_q      <= '0;
         period_q    <= '0;
         presc_q     <= '0;
         dt_q        <= '0;
         period_sh_q <= '0;
         presc_sh_q  <= '0;
         psc_q       <= '0;
         cnt_q       <= '0;
         dir_q       <= 1'b0;
         upd_q       <= 1'b0;
         ref_q       <= '0;
         pwm_h_q     <= '0;
         pwm_l_q     <= '0;
         rd_data_q   <= '0;
         for (int i = 0; i < NCH; i++) begin
            duty_q[i]    <= '0;
            duty_sh_q[i] <= '0;
            dtc_q[i]     <= '0;
         end
      end else begin
         ctrl_q      <= ctrl_d;
         period_q    <= period_d;
         presc_q     <= presc_d;
         dt_q        <= dt_d;
         period_sh_q <= period_sh_d;
         presc_sh_q  <= presc_sh_d;
         psc_q       <= psc_d;
         cnt_q       <= cnt_d;
         dir_q       <= dir_d;
         upd_q       <= upd_d;
         ref_q       <= ref_d;
         pwm_h_q     <= pwm_h_d;
         pwm_l_q     <= pwm_l_d;
         rd_data_q   <= rd_data_d;
         for (int i = 0; i < NCH; i++) begin
            duty_q[i]    <= duty_d[i];
            duty_sh_q[i] <= duty_sh_d[i];
            dtc_q[i]     <= dtc_d[i];
         end
      end
   end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// tb_pwm_multi_ch: directed bench for pwm_multi_ch (WIDTH=16, NCH=4, DT_W=8).
// Each scenario task drives the bus and checks outputs sampled on negedges.
module tb_pwm_multi_ch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_en = 1'b0;
   logic        rd_en = 1'b0;
   logic [3:0]  addr = '0;
   logic [15:0] wr_data = '0;
   logic [15:0] rd_data;
   logic [3:0]  pwm_h;
   logic [3:0]  pwm_l;
   logic        upd_evt;

   int n_cmp = 0;
   int n_bad = 0;

   pwm_multi_ch #(.WIDTH(16), .NCH(4), .DT_W(8)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
      .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
      .pwm_h(pwm_h), .pwm_l(pwm_l), .upd_evt(upd_evt)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wr(input logic [3:0] a, input logic [15:0] d);
      @(negedge clk);
      wr_en = 1'b1; addr = a; wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic rd(input logic [3:0] a, output logic [15:0] d);
      @(negedge clk);
      rd_en = 1'b1; addr = a;
      @(negedge clk);
      rd_en = 1'b0;
      d = rd_data;
   endtask

   function automatic logic sig(input int sel);
      case (sel)
         0: return pwm_h[0];
         1: return pwm_l[0];
         2: return pwm_h[1];
         default: return upd_evt;
      endcase
   endfunction

   // High and low run lengths of one full pulse of the selected signal.
   task automatic measure(input int sel, output int hi, output int lo);
      int t = 0;
      hi = 0; lo = 0;
      while (sig(sel) && t < 200) begin @(negedge clk); t++; end
      while (!sig(sel) && t < 200) begin @(negedge clk); t++; end
      while (sig(sel) && t < 200) begin hi++; @(negedge clk); t++; end
      while (!sig(sel) && t < 200) begin lo++; @(negedge clk); t++; end
   endtask

   task automatic wait_upd(output bit ok);
      int t = 0;
      do begin @(negedge clk); t++; end while (!upd_evt && t < 200);
      ok = upd_evt;
   endtask

   task automatic settle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic count_hi(input int sel, input int n, output int c);
      c = 0;
      for (int k = 0; k < n; k++) begin
         if (sig(sel)) c++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      logic [15:0] d;
      settle(3);
      rst = 1'b0;
      settle(1);
      n_cmp++;
      if (pwm_h !== 4'h0 || pwm_l !== 4'h0) begin
         n_bad++;
         $display("FAIL reset_pwm: h=%h l=%h want 0/0", pwm_h, pwm_l);
      end
      n_cmp++;
      if (upd_evt !== 1'b0 || rd_data !== 16'h0) begin
         n_bad++;
         $display("FAIL reset_misc: upd=%b rd=%h want 0/0", upd_evt, rd_data);
      end
      rd(4'd1, d);
      n_cmp++;
      if (d !== 16'h0) begin
         n_bad++;
         $display("FAIL reset_period: got %h want 0", d);
      end
   endtask

   task automatic test_edge;
      int hi, lo, n, bad;
      bit ok;
      wr(4'd1, 16'd9);
      wr(4'd2, 16'd0);
      wr(4'd4, 16'd3);
      wr(4'd3, 16'd0);
      wr(4'd0, 16'd1);
      settle(25);
      measure(0, hi, lo);
      n_cmp++;
      if (hi !== 3 || lo !== 7) begin
         n_bad++;
         $display("FAIL edge_duty: hi=%0d lo=%0d want 3/7", hi, lo);
      end
      wait_upd(ok);
      n = 0;
      do begin @(negedge clk); n++; end while (!upd_evt && n < 200);
      n_cmp++;
      if (!ok || n !== 10) begin
         n_bad++;
         $display("FAIL edge_upd_interval: got %0d want 10", n);
      end
      bad = 0;
      for (int k = 0; k < 30; k++) begin
         if (pwm_l[0] !== ~pwm_h[0]) bad++;
         @(negedge clk);
      end
      n_cmp++;
      if (bad !== 0) begin
         n_bad++;
         $display("FAIL edge_complement: %0d bad cycles want 0", bad);
      end
   endtask

   task automatic test_shadow;
      int c;
      bit ok;
      wait_upd(ok);
      wr(4'd4, 16'd7);
      count_hi(0, 10, c);
      n_cmp++;
      if (!ok || c !== 3) begin
         n_bad++;
         $display("FAIL shadow_cur: high=%0d want 3", c);
      end
      count_hi(0, 10, c);
      n_cmp++;
      if (c !== 7) begin
         n_bad++;
         $display("FAIL shadow_next: high=%0d want 7", c);
      end
      wait_upd(ok);
      settle(8);
      wr(4'd4, 16'd2);
      count_hi(0, 10, c);
      n_cmp++;
      if (!ok || c !== 7) begin
         n_bad++;
         $display("FAIL shadow_upd_cur: high=%0d want 7", c);
      end
      count_hi(0, 10, c);
      n_cmp++;
      if (c !== 2) begin
         n_bad++;
         $display("FAIL shadow_upd_next: high=%0d want 2", c);
      end
   endtask

   task automatic test_center;
      int hi, lo, n;
      bit ok;
      wr(4'd0, 16'd0);
      wr(4'd1, 16'd4);
      wr(4'd2, 16'd0);
      wr(4'd5, 16'd2);
      wr(4'd0, 16'd3);
      settle(30);
      measure(2, hi, lo);
      n_cmp++;
      if (hi !== 3 || lo !== 5) begin
         n_bad++;
         $display("FAIL center_duty: hi=%0d lo=%0d want 3/5", hi, lo);
      end
      wait_upd(ok);
      n = 0;
      do begin @(negedge clk); n++; end while (!upd_evt && n < 200);
      n_cmp++;
      if (!ok || n !== 8) begin
         n_bad++;
         $display("FAIL center_upd_interval: got %0d want 8", n);
      end
      wr(4'd2, 16'd1);
      settle(40);
      measure(2, hi, lo);
      n_cmp++;
      if (hi !== 6 || lo !== 10) begin
         n_bad++;
         $display("FAIL center_presc: hi=%0d lo=%0d want 6/10", hi, lo);
      end
   endtask

   task automatic test_deadtime;
      int ch, cl, both, none;
      wr(4'd0, 16'd0);
      wr(4'd2, 16'd0);
      wr(4'd1, 16'd9);
      wr(4'd4, 16'd5);
      wr(4'd3, 16'd3);
      wr(4'd0, 16'd1);
      settle(30);
      ch = 0; cl = 0; both = 0; none = 0;
      for (int k = 0; k < 40; k++) begin
         if (pwm_h[0]) ch++;
         if (pwm_l[0]) cl++;
         if (pwm_h[0] && pwm_l[0]) both++;
         if (!pwm_h[0] && !pwm_l[0]) none++;
         @(negedge clk);
      end
      n_cmp++;
      if (both !== 0) begin
         n_bad++;
         $display("FAIL dt_overlap: %0d cycles both high want 0", both);
      end
      n_cmp++;
      if (ch !== 8 || cl !== 8) begin
         n_bad++;
         $display("FAIL dt_on_time: h=%0d l=%0d want 8/8", ch, cl);
      end
      n_cmp++;
      if (none !== 24) begin
         n_bad++;
         $display("FAIL dt_gap: both-low %0d want 24", none);
      end
      wr(4'd3, 16'd8);
      settle(12);
      count_hi(0, 30, ch);
      n_cmp++;
      if (ch !== 0) begin
         n_bad++;
         $display("FAIL dt_long: h high %0d want 0", ch);
      end
      wr(4'd3, 16'd0);
   endtask

   task automatic test_boundaries;
      int c;
      logic [15:0] d;
      wr(4'd4, 16'd0);
      settle(25);
      count_hi(0, 30, c);
      n_cmp++;
      if (c !== 0) begin
         n_bad++;
         $display("FAIL duty_zero: h high %0d want 0", c);
      end
      wr(4'd4, 16'd10);
      settle(25);
      count_hi(0, 30, c);
      n_cmp++;
      if (c !== 30) begin
         n_bad++;
         $display("FAIL duty_full: h high %0d want 30", c);
      end
      wr(4'd1, 16'd0);
      wr(4'd2, 16'd2);
      settle(30);
      count_hi(3, 30, c);
      n_cmp++;
      if (c !== 10) begin
         n_bad++;
         $display("FAIL period_zero: upd %0d want 10", c);
      end
      wr(4'd15, 16'hABCD);
      rd(4'd15, d);
      n_cmp++;
      if (d !== 16'h0) begin
         n_bad++;
         $display("FAIL unmapped_read: got %h want 0", d);
      end
      wr(4'd3, 16'hFF05);
      rd(4'd3, d);
      n_cmp++;
      if (d !== 16'h0005) begin
         n_bad++;
         $display("FAIL dt_read: got %h want 0005", d);
      end
      wr(4'd3, 16'd0);
   endtask

   task automatic test_readback;
      logic [15:0] d;
      @(negedge clk);
      wr_en = 1'b1; rd_en = 1'b1; addr = 4'd1; wr_data = 16'd9;
      @(negedge clk);
      wr_en = 1'b0; rd_en = 1'b0;
      n_cmp++;
      if (rd_data !== 16'h0) begin
         n_bad++;
         $display("FAIL rw_same: got %h want 0", rd_data);
      end
      rd(4'd1, d);
      n_cmp++;
      if (d !== 16'd9) begin
         n_bad++;
         $display("FAIL period_read: got %h want 0009", d);
      end
      rd(4'd4, d);
      n_cmp++;
      if (d !== 16'd10) begin
         n_bad++;
         $display("FAIL duty_read: got %h want 000a", d);
      end
      rd(4'd2, d);
      n_cmp++;
      if (d !== 16'd2) begin
         n_bad++;
         $display("FAIL presc_read: got %h want 0002", d);
      end
   endtask

   task automatic test_disable_reset;
      int t, c;
      logic [15:0] d;
      wr(4'd2, 16'd0);
      wr(4'd4, 16'd5);
      settle(30);
      t = 0;
      while (!pwm_h[0] && t < 100) begin @(negedge clk); t++; end
      n_cmp++;
      if (!pwm_h[0]) begin
         n_bad++;
         $display("FAIL dis_wait_high: h=%b want 1", pwm_h[0]);
      end
      wr(4'd0, 16'd0);
      @(negedge clk);
      n_cmp++;
      if (pwm_h !== 4'h0 || pwm_l !== 4'h0) begin
         n_bad++;
         $display("FAIL disable_safe: h=%h l=%h want 0/0", pwm_h, pwm_l);
      end
      count_hi(3, 12, c);
      n_cmp++;
      if (c !== 0) begin
         n_bad++;
         $display("FAIL disable_upd: upd %0d want 0", c);
      end
      wr(4'd0, 16'd1);
      settle(25);
      rd(4'd1, d);
      n_cmp++;
      if (d !== 16'd9) begin
         n_bad++;
         $display("FAIL pre_reset_read: got %h want 0009", d);
      end
      t = 0;
      while (!pwm_h[0] && t < 100) begin @(negedge clk); t++; end
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if (pwm_h !== 4'h0 || pwm_l !== 4'h0 || upd_evt !== 1'b0) begin
         n_bad++;
         $display("FAIL async_rst_out: h=%h l=%h u=%b want 0", pwm_h, pwm_l, upd_evt);
      end
      n_cmp++;
      if (rd_data !== 16'h0) begin
         n_bad++;
         $display("FAIL async_rst_rd: got %h want 0", rd_data);
      end
      @(negedge clk);
      rst = 1'b0;
      rd(4'd1, d);
      n_cmp++;
      if (d !== 16'h0) begin
         n_bad++;
         $display("FAIL rst_period: got %h want 0", d);
      end
      rd(4'd4, d);
      n_cmp++;
      if (d !== 16'h0) begin
         n_bad++;
         $display("FAIL rst_duty: got %h want 0", d);
      end
      rd(4'd0, d);
      n_cmp++;
      if (d !== 16'h0) begin
         n_bad++;
         $display("FAIL rst_ctrl: got %h want 0", d);
      end
   endtask

   initial begin
      test_reset;
      test_edge;
      test_shadow;
      test_center;
      test_deadtime;
      test_boundaries;
      test_readback;
      test_disable_reset;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
